wrr_burst_arbiter: RTL and testbench
====================================

Name: wrr_burst_arbiter

Overview:
- Weighted round-robin arbiter that shares one downstream beat channel between N requesters.
- Grants are held for a burst of up to `weight[i]` accepted beats; grant ownership rotates fairly.
- Sits between the requester ports and the shared resource; the resource supplies `res_ready`, and the arbiter drives a registered one-hot grant plus a mux select.

Parameters:
- N, 6, number of requesters (≥2).
- WW, 4, width of each per-requester weight field.
- IW, $clog2(N), grant index width (derived; do not override).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request; must stay high while it has beats pending.
- last  input  N  per-requester end-of-burst marker, sampled only on an accepted beat.
- weight  input  N*WW  static burst credit per requester, field i at [i*WW +: WW]; change only while gnt_vld=0.
- res_ready  input  1  shared resource accepts a beat this cycle.
- gnt  output  N  registered one-hot grant.
- gnt_idx  output  IW  binary index of the current owner.
- gnt_vld  output  1  a grant is active (OR of gnt).

Behaviour:
- Reset values: gnt=0, gnt_idx=0, gnt_vld=0, credit=0, state=IDLE, last_owner=N-1, so the first search starts at index 0.
- Accepted beat: `gnt[i] & req[i] & res_ready`.
- Search function: scan indices (last_owner+1 .. last_owner+N) mod N, pick the first with req set. This is rotating priority; last_owner has lowest priority.
- Effective weight: `weight[i]==0` is treated as 1.
- IDLE:
  - If any req is set, register the search result: gnt, gnt_idx and gnt_vld rise on the next edge.
  - Load credit = effective weight and go to GRANT.
  - Latency is 1 cycle from req to gnt.
- GRANT: each accepted beat decrements credit. The burst ends on any of:
  - (a) an accepted beat with credit==1;
  - (b) an accepted beat with `last[owner]=1`;
  - (c) `req[owner]=0` with no beat that cycle.
- Release in the same cycle:
  - last_owner <= owner.
  - Search runs combinationally from owner+1, with the releasing owner excluded. If another requester is found, gnt moves to it on the next edge with no idle gap, and credit is reloaded.
  - If none is found but the old owner still requests (end by credit or last), the old owner is re-granted.
  - Otherwise go to IDLE with gnt=0.
- Simultaneous (a) and (b): a single release; no double counting.
- While gnt_vld=1, requests from non-owners never preempt the owner.
- `res_ready` low: credit holds and the grant holds.
- Index wrap: the search after owner N-1 continues at 0.
- Reset mid-burst: all state returns to reset values immediately (async). A burst in flight is abandoned; the requester re-requests after reset.
- Width rules: credit is WW bits. Decrement never underflows, because release at credit==1 prevents reaching 0 in GRANT.

Optional Feature:
- Macro: WRR_ARB_LOCK_EN.
- Defined: adds input `lock` (N bits). While `lock[owner]=1`, termination (a) is ignored and credit saturates at 1. The burst ends only via (b) or (c).
- Undefined: the port is absent and credit expiry always applies.

Decomposition:
- Shared package `arb_pkg`:
  - state enum {IDLE, GRANT}.
  - Function `rr_pick(req, start)` returning {found, idx}.
  - Constant for the effective-weight rule.
- One natural sub-module, `rr_pick_next`: a combinational rotating-priority picker (N, start index in, one-hot plus index plus found out). It is reused for the IDLE search and the release search.

Test Plan:
1. Reset/idle: hold rst_n=0 with req=6'b111111. Expect gnt=0 and gnt_vld=0. Release reset, keep req: gnt=6'b000001 exactly 1 cycle later.
2. Weighted burst: weight=all 2, req=6'b000101, res_ready=1. Expect grant sequence 0,0,2,2,0,0,… with no idle cycles at handover.
3. Last terminates early: weight[0]=4, beat 2 with last[0]=1, req[2]=1. Expect gnt moves to requester 2 after exactly 2 beats.
4. Backpressure/drop:
   - res_ready=0 for 5 cycles mid-burst: grant and credit unchanged.
   - Owner drops req with no beat: grant moves to the next requester next cycle, or gnt=0 if none.
5. Wrap and zero weight: owner=5, req=6'b100001, weight[5]=0. Expect 1 beat to 5, then grant to 0. Lone requester 3 with weight 1 is re-granted every cycle.
6. Async reset mid-burst plus lock:
   - rst_n pulse during GRANT: gnt=0 the same cycle; next grant restarts search at 0.
   - With WRR_ARB_LOCK_EN and lock[1]=1, weight[1]=1: owner 1 keeps its grant for 8 beats until last[1].

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority search used by the weighted round-robin burst arbiter.
package arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

  localparam int unsigned ARB_MAX_N  = 32;
  localparam int unsigned ARB_MAX_IW = 5;
  // A programmed weight of zero still earns one beat per turn.
  localparam int unsigned ARB_ZERO_WEIGHT_CREDIT = 1;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } pick_t;

  // Scans start, start+1, ... (mod n) and returns the first set request.
  function automatic pick_t rr_pick(input logic [ARB_MAX_N-1:0] req,
                                    input int unsigned n,
                                    input int unsigned start);
    pick_t       r;
    logic [31:0] i;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned k = 0; k < ARB_MAX_N; k++) begin
      i = start + k;
      if (i >= n) i = i - n;
      if (k < n && !r.found && i < ARB_MAX_N && req[i[ARB_MAX_IW-1:0]]) begin
        r.found = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick_next.sv
// Combinational rotating-priority picker: first set request at or after i_start, wrapping at N.
module rr_pick_next
  import arb_pkg::*;
#(
  parameter int N  = 6,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [ARB_MAX_N-1:0] w_req_ext;
  pick_t                w_pick;

  always_comb begin
    w_req_ext        = '0;
    w_req_ext[N-1:0] = i_req;
    w_pick           = rr_pick(w_req_ext, N, 32'(i_start));
  end

  assign o_found  = w_pick.found;
  assign o_idx    = IW'(w_pick.idx);
  assign o_onehot = w_pick.found ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin burst arbiter: 1-cycle req->gnt, back-to-back handover, grant and credit frozen while res_ready is low.
// Defining WRR_ARB_LOCK_EN adds a per-requester lock input that suppresses credit expiry for the locked owner.
module wrr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int N  = 6,
  parameter int WW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    last,
  input  logic [N*WW-1:0] weight,
  input  logic            res_ready,
`ifdef WRR_ARB_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  arb_state_e    r_state, w_state_nxt;
  logic [N-1:0]  r_gnt, w_gnt_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [IW-1:0] r_last_owner, w_last_owner_nxt;
  logic [WW-1:0] r_credit, w_credit_nxt;

  logic [WW-1:0] w_weight_arr [N];
  logic [WW-1:0] w_pick_weight, w_owner_weight;
  logic [WW-1:0] w_pick_credit, w_owner_credit;
  logic [IW-1:0] w_after_owner, w_after_last, w_search_start;
  logic [N-1:0]  w_search_req, w_pick_onehot;
  logic [IW-1:0] w_pick_idx;
  logic          w_pick_found;
  logic          w_owner_req, w_owner_last, w_owner_lock;
  logic          w_credit_one, w_beat, w_release;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_weight_arr[i] = weight[i*WW +: WW];
    end
  end

  assign w_pick_weight  = w_weight_arr[w_pick_idx];
  assign w_owner_weight = w_weight_arr[r_idx];
  assign w_pick_credit  = (w_pick_weight == '0)  ? WW'(ARB_ZERO_WEIGHT_CREDIT) : w_pick_weight;
  assign w_owner_credit = (w_owner_weight == '0) ? WW'(ARB_ZERO_WEIGHT_CREDIT) : w_owner_weight;

  assign w_after_owner = (r_idx == IW'(N-1))        ? '0 : r_idx + 1'b1;
  assign w_after_last  = (r_last_owner == IW'(N-1)) ? '0 : r_last_owner + 1'b1;

  // One picker serves both searches; on release the current owner is masked out.
  assign w_search_start = (r_state == GRANT) ? w_after_owner : w_after_last;
  assign w_search_req   = (r_state == GRANT) ? (req & ~r_gnt) : req;

  rr_pick_next #(.N(N), .IW(IW)) u_pick (
    .i_req    (w_search_req),
    .i_start  (w_search_start),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_found  (w_pick_found)
  );

  assign w_owner_req  = req[r_idx];
  assign w_owner_last = last[r_idx];
`ifdef WRR_ARB_LOCK_EN
  assign w_owner_lock = lock[r_idx];
`else
  assign w_owner_lock = 1'b0;
`endif

  assign w_credit_one = (r_credit == WW'(1));
  assign w_beat       = (r_state == GRANT) & w_owner_req & res_ready;
  assign w_release    = (r_state == GRANT) &
                        ((w_beat & ((w_credit_one & ~w_owner_lock) | w_owner_last)) | ~w_owner_req);

  always_comb begin
    w_state_nxt      = r_state;
    w_gnt_nxt        = r_gnt;
    w_idx_nxt        = r_idx;
    w_last_owner_nxt = r_last_owner;
    w_credit_nxt     = r_credit;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_nxt  = GRANT;
          w_gnt_nxt    = w_pick_onehot;
          w_idx_nxt    = w_pick_idx;
          w_credit_nxt = w_pick_credit;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_last_owner_nxt = r_idx;
          if (w_pick_found) begin
            w_gnt_nxt    = w_pick_onehot;
            w_idx_nxt    = w_pick_idx;
            w_credit_nxt = w_pick_credit;
          end else if (w_owner_req) begin
            w_credit_nxt = w_owner_credit;
          end else begin
            w_state_nxt  = IDLE;
            w_gnt_nxt    = '0;
            w_idx_nxt    = '0;
            w_credit_nxt = '0;
          end
        end else if (w_beat && !w_credit_one) begin
          // A locked owner sitting at credit 1 keeps 1 instead of wrapping.
          w_credit_nxt = r_credit - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_gnt        <= '0;
      r_idx        <= '0;
      r_last_owner <= IW'(N-1);
      r_credit     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_idx        <= w_idx_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_credit     <= w_credit_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = |r_gnt;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Bench for wrr_burst_arbiter: vector table, hand-written corner sequences, randomized run against a reference model.
module tb_wrr_burst_arbiter;

  localparam int N  = 6;
  localparam int WW = 4;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    last = '0;
  logic [N*WW-1:0] weight = '0;
  logic            res_ready = 1'b0;
  logic [N-1:0]    lock = '0;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_vld;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wrr_burst_arbiter #(.N(N), .WW(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .weight    (weight),
    .res_ready (res_ready),
`ifdef WRR_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld)
  );

  // Reference model: owner, remaining beats and previous owner as plain integers.
  int m_vld, m_own, m_cred, m_lastown;

  function automatic int eff_w(int i);
    int w;
    w = int'(weight[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int search(int start, int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (req[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_own = 0; m_cred = 0; m_lastown = N - 1;
  endtask

  task automatic model_step();
    int s;
    bit beat, fin;
    if (m_vld == 0) begin
      s = search((m_lastown + 1) % N, -1);
      if (s >= 0) begin m_vld = 1; m_own = s; m_cred = eff_w(s); end
    end else begin
      beat = req[m_own] && res_ready;
      fin  = (beat && ((m_cred == 1 && !lock[m_own]) || last[m_own])) || !req[m_own];
      if (fin) begin
        m_lastown = m_own;
        s = search((m_own + 1) % N, m_own);
        if (s >= 0) begin m_own = s; m_cred = eff_w(s); end
        else if (req[m_own]) m_cred = eff_w(m_own);
        else m_vld = 0;
      end else if (beat) begin
        m_cred = (m_cred > 1) ? m_cred - 1 : 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_gnt(input string name, input logic [N-1:0] exp);
    check({name, "_gnt"}, 32'(gnt), 32'(exp));
    check({name, "_vld"}, 32'(gnt_vld), 32'(|exp));
    if (exp != '0) check({name, "_idx"}, 32'(gnt_idx), 32'(onehot_idx(exp)));
  endtask

  task automatic check_model();
    check("rnd_gnt", 32'(gnt), (m_vld != 0) ? (32'd1 << m_own) : 32'd0);
    check("rnd_vld", 32'(gnt_vld), 32'(m_vld));
    if (m_vld != 0) check("rnd_idx", 32'(gnt_idx), 32'(m_own));
  endtask

  typedef struct {
    bit              rst;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    bit              rr;
    logic [N*WW-1:0] weight;
    logic [N-1:0]    exp_gnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, logic [N-1:0] rq, logic [N-1:0] ls, bit rr,
                              logic [N*WW-1:0] w, logic [N-1:0] eg);
    vec_t v;
    v.rst = rst; v.req = rq; v.last = ls; v.rr = rr; v.weight = w; v.exp_gnt = eg;
    tbl.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // Reset holds grant low even with every requester asking; first grant one edge after release.
    req = 6'b111111; res_ready = 1'b1; weight = 24'h111111;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_gnt("reset_hold", 6'b000000);
    rst_n = 1'b1;
    model_reset();
    #1;
    check_gnt("pre_edge", 6'b000000);
    tick();
    check_gnt("first_gnt", 6'b000001);

    // Weighted bursts of 2, no idle at handover.
    add(1, 6'b000101, 6'b0, 1, 24'h222222, 6'b000001);
    add(0, 6'b000101, 6'b0, 1, 24'h222222, 6'b000001);
    add(0, 6'b000101, 6'b0, 1, 24'h222222, 6'b000100);
    add(0, 6'b000101, 6'b0, 1, 24'h222222, 6'b000100);
    add(0, 6'b000101, 6'b0, 1, 24'h222222, 6'b000001);
    add(0, 6'b000101, 6'b0, 1, 24'h222222, 6'b000001);
    add(0, 6'b000101, 6'b0, 1, 24'h222222, 6'b000100);
    // last ends a weight-4 burst after 2 beats.
    add(1, 6'b000101, 6'b000000, 1, 24'h111214, 6'b000001);
    add(0, 6'b000101, 6'b000000, 1, 24'h111214, 6'b000001);
    add(0, 6'b000101, 6'b000001, 1, 24'h111214, 6'b000100);
    add(0, 6'b000101, 6'b000000, 1, 24'h111214, 6'b000100);
    add(0, 6'b000101, 6'b000000, 1, 24'h111214, 6'b000001);
    // Wrap 5 -> 0 with weight[5]=0 acting as 1.
    add(1, 6'b100001, 6'b0, 1, 24'h011111, 6'b000001);
    add(0, 6'b100001, 6'b0, 1, 24'h011111, 6'b100000);
    add(0, 6'b100001, 6'b0, 1, 24'h011111, 6'b000001);
    add(0, 6'b100001, 6'b0, 1, 24'h011111, 6'b100000);
    // Lone requester with weight 1 is re-granted every cycle.
    add(1, 6'b001000, 6'b0, 1, 24'h111111, 6'b001000);
    add(0, 6'b001000, 6'b0, 1, 24'h111111, 6'b001000);
    add(0, 6'b001000, 6'b0, 1, 24'h111111, 6'b001000);
    // Backpressure for 5 cycles freezes grant and credit.
    add(1, 6'b000011, 6'b0, 1, 24'h333333, 6'b000001);
    add(0, 6'b000011, 6'b0, 1, 24'h333333, 6'b000001);
    for (int i = 0; i < 5; i++) add(0, 6'b000011, 6'b0, 0, 24'h333333, 6'b000001);
    add(0, 6'b000011, 6'b0, 1, 24'h333333, 6'b000001);
    add(0, 6'b000011, 6'b0, 1, 24'h333333, 6'b000010);
    // Owner drops request: handover, then idle, then a fresh request.
    add(1, 6'b000011, 6'b0, 1, 24'h444444, 6'b000001);
    add(0, 6'b000011, 6'b0, 1, 24'h444444, 6'b000001);
    add(0, 6'b000010, 6'b0, 1, 24'h444444, 6'b000010);
    add(0, 6'b000000, 6'b0, 1, 24'h444444, 6'b000000);
    add(0, 6'b000000, 6'b0, 1, 24'h444444, 6'b000000);
    add(0, 6'b000100, 6'b0, 1, 24'h444444, 6'b000100);
    // A new requester does not preempt the owner mid-burst.
    add(1, 6'b000010, 6'b0, 1, 24'h444444, 6'b000010);
    add(0, 6'b000011, 6'b0, 1, 24'h444444, 6'b000010);
    add(0, 6'b000011, 6'b0, 1, 24'h444444, 6'b000010);
    add(0, 6'b000011, 6'b0, 1, 24'h444444, 6'b000010);
    add(0, 6'b000011, 6'b0, 1, 24'h444444, 6'b000001);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      req = tbl[i].req; last = tbl[i].last; res_ready = tbl[i].rr; weight = tbl[i].weight;
      tick();
      check_gnt($sformatf("vec%0d", i), tbl[i].exp_gnt);
    end

    // Async reset mid-burst drops the grant without a clock edge; search restarts at 0.
    do_reset();
    weight = 24'h444444; req = 6'b000100; last = '0; res_ready = 1'b1;
    tick();
    check_gnt("mid_start", 6'b000100);
    req = 6'b000110;
    tick();
    check_gnt("mid_hold", 6'b000100);
    #3 rst_n = 1'b0;
    #1;
    check_gnt("async_rst", 6'b000000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    tick();
    check_gnt("after_rst", 6'b000010);

`ifdef WRR_ARB_LOCK_EN
    // Locked owner with weight 1 keeps the grant for 8 beats, ending on last.
    do_reset();
    weight = 24'h111111; lock = 6'b000010; req = 6'b000010; last = '0; res_ready = 1'b1;
    tick();
    check_gnt("lock_start", 6'b000010);
    req = 6'b000011;
    for (int b = 0; b < 7; b++) begin
      tick();
      check_gnt($sformatf("lock_beat%0d", b + 1), 6'b000010);
    end
    last = 6'b000010;
    tick();
    check_gnt("lock_end", 6'b000001);
    last = '0; lock = '0;
`endif

    // Randomized run against the reference model.
    for (int e = 0; e < 8; e++) begin
      weight = {$urandom, $urandom} & 24'hFFFFFF;
`ifdef WRR_ARB_LOCK_EN
      lock = 6'($urandom);
`endif
      do_reset();
      for (int c = 0; c < 250; c++) begin
        req       = 6'($urandom | $urandom);
        last      = 6'($urandom & $urandom);
        res_ready = ($urandom_range(0, 3) != 0);
        tick();
        check_model();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
